// File: rtl/uart_pkg.sv
// Framing constants and state encoding shared by the UART transmitter and receiver,
// so both ends of a link agree on parity modes and oversampling.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Even mode yields the XOR of the byte, odd mode its inverse; none yields 0.
    function automatic logic parity_bit(input logic [7:0] value, input int mode);
        logic x;
        x = ^value;
        if (mode == PARITY_EVEN) begin
            return x;
        end else if (mode == PARITY_ODD) begin
            return ~x;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// each bit held for OVERSAMPLE clocks. Start/busy/done handshake toward the client.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       TX,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    if (OVERSAMPLE < 2) begin : g_bad_oversample
        $error("uart_tx: OVERSAMPLE must be at least 2");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        done_d     = 1'b0;
        tx_d       = 1'b1;

        bit_end = (cnt_q == CNT_LAST);
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_START;
                    shift_d    = data;
                    parity_d   = parity_bit(data, PARITY);
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // TX is registered, so its next value follows the state being entered.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign TX   = tx_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances cover no parity, even, odd and two stop bits;
// a scoreboard of sent bytes is checked cycle by cycle against TX, plus a receiver model for loopback.
module tb_uart_tx;

    localparam int OS = 16;

    typedef struct {
        int         inst;
        logic [7:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_w;
    logic [7:0] data_w [4];
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int par_cfg  [4] = '{0, 2, 1, 0};
    int stop_cfg [4] = '{1, 1, 1, 2};

    exp_t       exp_q [$];
    logic [7:0] rx_q  [$];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_done_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .data(data_w[0]),
        .TX(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );
    uart_tx #(.OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .data(data_w[1]),
        .TX(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );
    uart_tx #(.OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .data(data_w[2]),
        .TX(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );
    uart_tx #(.OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_w[3]), .data(data_w[3]),
        .TX(tx_w[3]), .busy(busy_w[3]), .done(done_w[3])
    );

    // Independent receiver on instance 0: finds the start edge, samples mid-bit.
    initial begin : rx_model
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (tx_w[0] === 1'b0) begin
                repeat (7) @(negedge clk);
                if (tx_w[0] === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (OS) @(negedge clk);
                        rb[i] = tx_w[0];
                    end
                    repeat (OS) @(negedge clk);
                    if (tx_w[0] === 1'b1) rx_q.push_back(rb);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first busy cycle.
    task automatic applyStimulus(input int k, input logic [7:0] b);
        exp_t e;
        e.inst = k;
        e.b    = b;
        exp_q.push_back(e);
        start_w[k] = 1'b1;
        data_w[k]  = b;
        @(negedge clk);
        start_w[k] = 1'b0;
    endtask

    // Checks a whole frame cycle by cycle; returns at the negedge of the done cycle.
    task automatic checkFrame(input int k);
        exp_t       e;
        logic       bits [12];
        int         n;
        int         busy_cnt;
        int         early_done;
        logic       seen;
        checkOutput($sformatf("inst%0d scoreboard entry", k), exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        checkOutput($sformatf("inst%0d scoreboard owner", k), e.inst, k);
        n = 0;
        bits[n++] = 1'b0;
        for (int i = 0; i < 8; i++) bits[n++] = e.b[i];
        if (par_cfg[k] == 2) bits[n++] = ^e.b;
        if (par_cfg[k] == 1) bits[n++] = ~(^e.b);
        for (int s = 0; s < stop_cfg[k]; s++) bits[n++] = 1'b1;
        busy_cnt   = 0;
        early_done = 0;
        for (int i = 0; i < n; i++) begin
            seen = bits[i];
            for (int c = 0; c < OS; c++) begin
                if (tx_w[k] !== bits[i]) seen = tx_w[k];
                if (busy_w[k] === 1'b1) busy_cnt++;
                if (done_w[k] !== 1'b0) early_done++;
                @(negedge clk);
            end
            checkOutput($sformatf("inst%0d byte %0h bit%0d", k, e.b, i), seen, bits[i]);
        end
        checkOutput($sformatf("inst%0d busy cycles", k), busy_cnt, n * OS);
        checkOutput($sformatf("inst%0d done during frame", k), early_done, 0);
        checkOutput($sformatf("inst%0d done pulse", k), done_w[k], 1);
        checkOutput($sformatf("inst%0d busy after frame", k), busy_w[k], 0);
        checkOutput($sformatf("inst%0d TX after frame", k), tx_w[k], 1);
        last_done_cyc = cyc;
    endtask

    initial begin : main
        int unsigned d1;
        int          pulses;
        int          busy_seen;
        logic [7:0]  lb [$];
        rst     = 1'b1;
        start_w = '0;
        for (int k = 0; k < 4; k++) data_w[k] = 8'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("reset TX inst%0d", k), tx_w[k], 1);
            checkOutput($sformatf("reset busy inst%0d", k), busy_w[k], 0);
            checkOutput($sformatf("reset done inst%0d", k), done_w[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic frame 0xA5");
        applyStimulus(0, 8'hA5);
        checkFrame(0);
        @(negedge clk);
        checkOutput("done is single cycle", done_w[0], 0);

        $display("[TB] parity and stop bit variants on 0x07");
        for (int k = 1; k < 4; k++) begin
            applyStimulus(k, 8'h07);
            checkFrame(k);
            @(negedge clk);
        end

        $display("[TB] back-to-back frames");
        applyStimulus(0, 8'h00);
        checkFrame(0);
        d1 = last_done_cyc;
        applyStimulus(0, 8'hFF);
        checkFrame(0);
        checkOutput("done spacing", last_done_cyc - d1, 161);
        @(negedge clk);

        $display("[TB] start while busy is ignored");
        applyStimulus(0, 8'h81);
        fork
            checkFrame(0);
            begin
                repeat (49) @(negedge clk);
                start_w[0] = 1'b1;
                data_w[0]  = 8'h3C;
                @(negedge clk);
                start_w[0] = 1'b0;
            end
        join
        pulses    = 0;
        busy_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) pulses++;
            if (busy_w[0] === 1'b1) busy_seen++;
        end
        checkOutput("ignored start: extra done", pulses, 0);
        checkOutput("ignored start: extra busy", busy_seen, 0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h77);
        repeat (69) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid reset TX", tx_w[0], 1);
        checkOutput("mid reset busy", busy_w[0], 0);
        checkOutput("mid reset done", done_w[0], 0);
        // The aborted frame never completes, so its scoreboard entry is retired here.
        void'(exp_q.pop_front());
        pulses    = 0;
        busy_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) pulses++;
            if (busy_w[0] === 1'b1) busy_seen++;
        end
        checkOutput("after reset: done pulses", pulses, 0);
        checkOutput("after reset: busy", busy_seen, 0);
        applyStimulus(0, 8'h5A);
        checkFrame(0);
        @(negedge clk);

        $display("[TB] start and reset together");
        start_w[0] = 1'b1;
        data_w[0]  = 8'h11;
        rst        = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        start_w[0] = 1'b0;
        checkOutput("start+rst busy", busy_w[0], 0);
        checkOutput("start+rst TX", tx_w[0], 1);
        @(negedge clk);
        checkOutput("start+rst dropped", busy_w[0], 0);

        $display("[TB] loopback");
        repeat (200) @(negedge clk);
        rx_q.delete();
        lb = '{8'h00, 8'h55, 8'hAA, 8'hFF};
        for (int i = 0; i < 256; i++) lb.push_back(8'($urandom_range(0, 255)));
        foreach (lb[i]) begin
            applyStimulus(0, lb[i]);
            checkFrame(0);
            @(negedge clk);
            checkOutput($sformatf("loopback %0d received", i), rx_q.size(), 1);
            if (rx_q.size() > 0) begin
                checkOutput($sformatf("loopback %0d byte", i), rx_q.pop_front(), lb[i]);
            end
            rx_q.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. Serialises one byte per request onto the TX line: start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits. It is clocked at 16x the baud rate, the same clock the UART receiver uses, so a tx/rx pair shares one clock domain. It sits between a byte-producing client and the external TX pin, with a simple start/busy/done handshake.

Parameters:
OVERSAMPLE, 16, clk cycles per bit period; integer >= 2; the counter width is derived from it.
PARITY, 0, 0 = none, 1 = odd, 2 = even; any other value is illegal (elaboration error).
STOP_BITS, 1, number of stop bits; 1 or 2 only.

Ports:
clk  input  1  clock at OVERSAMPLE x baudrate; single clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  transmit request; sampled only while busy=0.
data  input  8  byte to send; captured in the same cycle start is accepted.
TX  output  1  UART transmit line; idle high.
busy  output  1  high while a frame is on TX.
done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset is synchronous and active-high. It is checked on each posedge clk and overrides all other activity. After reset: TX=1, busy=0, done=0, state=IDLE, all counters 0.
- The frame is FRAME_BITS = 1 + 8 + (PARITY!=0) + STOP_BITS bits. Default: 10 bits, i.e. 160 clk cycles.
- State machine: IDLE -> START -> DATA (8 bits) -> PARITY (skipped when PARITY=0) -> STOP (STOP_BITS periods) -> IDLE.
- Acceptance happens in any cycle with state=IDLE and start=1:
  - data is latched into the shift register.
  - The parity bit is computed from the latched byte. Even: XOR of the bits. Odd: the inverse of that.
  - The next cycle TX=0 (start bit) and busy=1.
- Each bit holds TX constant for exactly OVERSAMPLE cycles, timed by a bit counter that runs 0..OVERSAMPLE-1 and wraps. The state or bit advances on the cycle the counter equals OVERSAMPLE-1.
- Data bits are sent LSB first (data[0] first). A 3-bit index counts 0..7.
- The stop bit(s) drive TX=1.
- busy is high for exactly FRAME_BITS*OVERSAMPLE consecutive cycles.
- In the first cycle after the last stop-bit cycle:
  - busy=0, done=1 for one cycle, TX=1, state=IDLE.
- Back-to-back: start=1 in the done cycle is accepted. The new start bit begins the following cycle, so there is 1 clk of extra idle between frames.
- start while busy=1 is ignored: not queued, no error.
- Changing data while busy has no effect on the frame in flight.
- rst mid-frame: the frame is abandoned. The next cycle TX=1, busy=0, and done is not pulsed.
- start and rst high in the same cycle: rst wins and the request is dropped.
- TX is driven from a register, with no combinational path from inputs to TX.

Decomposition:
- Shared uart package:
  - parity encodings PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2
  - default OVERSAMPLE=16
  - IDLE/START/DATA/PARITY/STOP state encoding
- The receiver imports the same package so both ends agree on framing constants.
- No sub-module. The bit-period counter, shift register and FSM all live in uart_tx.

Test Plan:
1. Defaults, start=1 for 1 cycle with data=8'hA5 -> TX emits 0,1,0,1,0,0,1,0,1,1, each held exactly 16 cycles. busy is high for 160 cycles. done pulses once on cycle 161 after acceptance.
2. Parity on data=8'h07:
   - PARITY=2 -> parity bit=1.
   - PARITY=1 -> parity bit=0.
   - In both cases busy is high 176 cycles.
   - STOP_BITS=2 with PARITY=0 -> TX high for 32 cycles after bit 7, busy 176 cycles.
3. Back-to-back: send 8'h00, then assert start with data=8'hFF in the done cycle -> exactly 1 idle-high cycle, then the second frame (0, eight 1s, 1). Two done pulses 161 cycles apart.
4. Assert start with data=8'h3C at cycle 50 of a frame carrying 8'h81 -> ignored. Only 8'h81 appears on TX, and only one done pulse.
5. Assert rst at cycle 70 of a frame -> next cycle TX=1, busy=0, no done pulse. A subsequent start with 8'h5A transmits a correct full frame.
6. Loopback of uart_tx into the UART receiver on the same clk, sending 0x00, 0x55, 0xAA, 0xFF, plus 256 random bytes -> every received byte equals the byte sent.
